// File: rtl/regfile_dump_unit.sv
// regfile_dump_unit: halts the CPU after DUMP_CYCLE cycles or on a manual
// trigger, then streams a frame of HDR_BYTE followed by all 32 registers
// (MSB first, register 0 first) over a valid/ready byte interface.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   trigger    manual dump request (level or pulse), honoured only while running
//   cpu_halt   freezes the CPU while high
//   rf_raddr   register-file read address (registered)
//   rf_rdata   register-file read data, combinational from rf_raddr
//   tx_data    stream byte
//   tx_valid   tx_data valid
//   tx_ready   consumer ready; transfer on an edge with tx_valid & tx_ready
//   done       frame complete (terminal until reset)
//   cycle_cnt  CPU cycles elapsed since reset, frozen once the dump starts
module regfile_dump_unit #(
  parameter int unsigned DUMP_CYCLE = 152,
  parameter logic [7:0]  HDR_BYTE   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trigger,
  output logic        cpu_halt,
  output logic [4:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        done,
  output logic [31:0] cycle_cnt
);

  localparam logic [2:0] S_RUN   = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [31:0] LAST_RUN_CNT = DUMP_CYCLE - 32'd1;

  logic [2:0]  state;
  logic [31:0] shreg;
  logic [1:0]  byte_idx;
  logic        xfer;

  assign xfer = tx_valid & tx_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_RUN;
      cycle_cnt <= '0;
      cpu_halt  <= 1'b0;
      rf_raddr  <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      done      <= 1'b0;
      shreg     <= '0;
      byte_idx  <= '0;
    end else begin
      case (state)
        S_RUN: begin
          cycle_cnt <= cycle_cnt + 32'd1;
          if ((cycle_cnt == LAST_RUN_CNT) || trigger) begin
            state    <= S_HDR;
            cpu_halt <= 1'b1;
            tx_data  <= HDR_BYTE;
            tx_valid <= 1'b1;
            rf_raddr <= '0;
          end
        end

        S_HDR: begin
          if (xfer) begin
            tx_valid <= 1'b0;
            state    <= S_LATCH;
          end
        end

        S_LATCH: begin
          shreg    <= rf_rdata;
          tx_data  <= rf_rdata[31:24];
          tx_valid <= 1'b1;
          byte_idx <= '0;
          state    <= S_SEND;
        end

        S_SEND: begin
          if (xfer) begin
            if (byte_idx == 2'd3) begin
              tx_valid <= 1'b0;
              if (rf_raddr == 5'd31) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                rf_raddr <= rf_raddr + 5'd1;
                state    <= S_LATCH;
              end
            end else begin
              // Rotate rather than shift: the byte on tx_data is always
              // shreg[31:24], so the next one is shreg[23:16].
              shreg    <= {shreg[23:0], shreg[31:24]};
              tx_data  <= shreg[23:16];
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end

        S_DONE: begin
          // Terminal until reset.
        end

        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_unit.sv
module tb_regfile_dump_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_trig, b_trig, a_rdy, b_rdy;
  logic        a_halt, b_halt, a_valid, b_valid, a_done, b_done;
  logic [4:0]  a_raddr, b_raddr;
  logic [31:0] a_rdata, b_rdata, a_cnt, b_cnt;
  logic [7:0]  a_data, b_data;

  int checks = 0;
  int errors = 0;
  int got;

  always #5 clk = ~clk;

  // DUT A register file: reg[i] = i * 32'h01010101
  assign a_rdata = {4{3'b000, a_raddr}};

  // DUT B register file: distinct bytes per position, exposes byte order
  function automatic logic [31:0] rf_b(input logic [4:0] a);
    return {3'b000, a, 3'b111, ~a, 8'h40 + {3'b000, a}, 8'hC0 ^ {3'b000, a}};
  endfunction
  assign b_rdata = rf_b(b_raddr);

  regfile_dump_unit #(.DUMP_CYCLE(4), .HDR_BYTE(8'hA5)) dut_a (
    .clk(clk), .rst(rst), .trigger(a_trig), .cpu_halt(a_halt),
    .rf_raddr(a_raddr), .rf_rdata(a_rdata), .tx_data(a_data),
    .tx_valid(a_valid), .tx_ready(a_rdy), .done(a_done), .cycle_cnt(a_cnt)
  );

  regfile_dump_unit #(.DUMP_CYCLE(100), .HDR_BYTE(8'hA5)) dut_b (
    .clk(clk), .rst(rst), .trigger(b_trig), .cpu_halt(b_halt),
    .rf_raddr(b_raddr), .rf_rdata(b_rdata), .tx_data(b_data),
    .tx_valid(b_valid), .tx_ready(b_rdy), .done(b_done), .cycle_cnt(b_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Byte k of a frame: 0 is the header, then 4 bytes per register MSB first.
  function automatic logic [7:0] exp_byte(input int which, input int k);
    logic [4:0]  r;
    int          b;
    logic [31:0] w;
    if (k == 0) return 8'hA5;
    r = 5'((k - 1) / 4);
    b = (k - 1) % 4;
    w = (which != 0) ? rf_b(r) : {4{3'b000, r}};
    w = w >> (8 * (3 - b));
    return w[7:0];
  endfunction

  // Receive nbytes from DUT A (which=0) or B (which=1) with tx_ready high
  // one cycle in `period`. DUT A's trigger is held high while the count of
  // received bytes lies in [trig_lo, trig_hi].
  task automatic run_frame(input int which, input int period, input int nbytes,
                           input int trig_lo, input int trig_hi, output int n);
    int         cyc = 0;
    logic       pv = 1'b0, pr = 1'b0, v, r;
    logic [7:0] pd = '0, d;
    n = 0;
    while (n < nbytes && cyc < 3000) begin
      @(negedge clk);
      v = (which != 0) ? b_valid : a_valid;
      d = (which != 0) ? b_data : a_data;
      if (pv && !pr) begin
        chk("hold_valid", 32'(v), 32'd1);
        chk("hold_data", 32'(d), 32'(pd));
      end
      r = ((cyc % period) == 0);
      if (which != 0) b_rdy = r; else a_rdy = r;
      a_trig = (which == 0) && (n >= trig_lo) && (n <= trig_hi);
      if (v && r) begin
        chk($sformatf("byte%0d", n), 32'(d), 32'(exp_byte(which, n)));
        n++;
      end
      pv = v; pr = r; pd = d;
      cyc++;
    end
    chk("frame_bytes", 32'(n), 32'(nbytes));
  endtask

  initial begin
    rst = 1'b0; a_trig = 1'b0; b_trig = 1'b0; a_rdy = 1'b0; b_rdy = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cnt", a_cnt, 32'd0);
    chk("rst_halt", 32'(a_halt), 32'd0);
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_data", 32'(a_data), 32'd0);
    chk("rst_raddr", 32'(a_raddr), 32'd0);
    rst = 1'b1;

    // Edges 1,2: both counting.
    repeat (2) @(negedge clk);
    chk("cnt_e2", a_cnt, 32'd2);
    b_trig = 1'b1;
    @(negedge clk);
    b_trig = 1'b0;
    chk("a_cnt_e3", a_cnt, 32'd3);
    chk("a_halt_e3", 32'(a_halt), 32'd0);
    chk("b_cnt_trig", b_cnt, 32'd3);
    chk("b_halt_trig", 32'(b_halt), 32'd1);
    chk("b_hdr_valid", 32'(b_valid), 32'd1);
    chk("b_hdr_data", 32'(b_data), 32'hA5);
    @(negedge clk);
    chk("a_halt_e4", 32'(a_halt), 32'd1);
    chk("a_cnt_e4", a_cnt, 32'd4);
    chk("a_hdr_valid", 32'(a_valid), 32'd1);
    chk("a_hdr_data", 32'(a_data), 32'hA5);
    chk("b_cnt_frozen", b_cnt, 32'd3);

    // Header stalled for 1000 cycles.
    repeat (1000) begin
      @(negedge clk);
      chk("stall_valid", 32'(a_valid), 32'd1);
      chk("stall_data", 32'(a_data), 32'hA5);
      chk("stall_cnt", a_cnt, 32'd4);
    end

    run_frame(0, 1, 129, 1000, -1, got);
    repeat (3) @(negedge clk);
    chk("a_done", 32'(a_done), 32'd1);
    chk("a_done_halt", 32'(a_halt), 32'd1);
    chk("a_done_valid", 32'(a_valid), 32'd0);
    chk("a_done_cnt", a_cnt, 32'd4);
    chk("a_done_raddr", 32'(a_raddr), 32'd31);

    run_frame(1, 3, 129, 1000, -1, got);
    repeat (3) @(negedge clk);
    chk("b_done", 32'(b_done), 32'd1);
    chk("b_done_valid", 32'(b_valid), 32'd0);
    chk("b_done_cnt", b_cnt, 32'd3);

    // Fresh run, abort after the 50th byte transfer.
    @(negedge clk);
    rst = 1'b0; a_rdy = 1'b0; b_rdy = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_frame(0, 3, 50, 1000, -1, got);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort_cnt", a_cnt, 32'd0);
    chk("abort_halt", 32'(a_halt), 32'd0);
    chk("abort_valid", 32'(a_valid), 32'd0);
    chk("abort_data", 32'(a_data), 32'd0);
    chk("abort_raddr", 32'(a_raddr), 32'd0);
    chk("abort_done", 32'(a_done), 32'd0);
    a_rdy = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Trigger and threshold coincide on edge 4.
    repeat (3) @(negedge clk);
    chk("re_cnt_e3", a_cnt, 32'd3);
    chk("re_halt_e3", 32'(a_halt), 32'd0);
    a_trig = 1'b1;
    @(negedge clk);
    a_trig = 1'b0;
    chk("re_cnt_e4", a_cnt, 32'd4);
    chk("re_halt_e4", 32'(a_halt), 32'd1);
    chk("re_hdr_data", 32'(a_data), 32'hA5);

    // Trigger held during part of SEND must not disturb the frame.
    run_frame(0, 1, 129, 10, 60, got);
    a_trig = 1'b0;
    repeat (2) @(negedge clk);
    a_trig = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("done_trig_valid", 32'(a_valid), 32'd0);
      chk("done_trig_done", 32'(a_done), 32'd1);
    end
    a_trig = 1'b0;
    chk("final_cnt", a_cnt, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
